i2c_reg_target: RTL
===================

# i2c_reg_target

I2C target (responder) that gives the dice design a register-access port over two open-drain pins. It oversamples SCL and SDA on the system clock and detects START, repeated START and STOP conditions. It decodes a 7-bit address and a sub-address pointer, then issues single-cycle register writes or serves register reads, auto-incrementing the pointer after every byte. It sits between the `uio` pad bits and the dice register file inside `tt_um_sanojn_ttrpg_dice`.

## Interface
- `ADDR`, default 7'h70: 7-bit target address.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `scl_in` in 1: SCL pad input, asynchronous.
- `sda_in` in 1: SDA pad input, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low. The pad output value is tied 0. Never drives high.
- `wr_en` out 1: one-cycle register write strobe.
- `wr_addr` out 8: write register address.
- `wr_data` out 8: write data.
- `rd_addr` out 8: read register address, equal to the pointer.
- `rd_data` in 8: register contents at `rd_addr`, combinational from the register file.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Pads pass through a 2-FF synchronizer, then a third "previous" stage.
- Edge detection:
  - `scl_rise` / `scl_fall`: SCL transitions.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- START in any state goes to ADDR, clears the bit counter and releases `sda_oe`. The pointer is retained.
- STOP in any state goes to IDLE and releases `sda_oe`. A partial byte is discarded and no `wr_en` is issued.
- Data is sampled MSB first on `scl_rise`. Target-driven SDA changes only on `scl_fall`.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If bits[7:1] == ADDR, go to ADDR_ACK. Otherwise go to IDLE (no ACK), ignoring traffic until the next START.
  - ADDR_ACK: assert `sda_oe` from the `scl_fall` after bit 8 to the next `scl_fall`. Then:
    - R/W = 0: go to SUB.
    - R/W = 1: load the shift register from `rd_data`, go to RDATA.
  - SUB: shift 8 bits, pointer ← byte, then SUB_ACK (ACK as above), then WDATA.
  - WDATA: shift 8 bits. On the 8th `scl_rise`, one cycle later: `wr_en` = 1, `wr_addr` = pointer, `wr_data` = byte. Pointer then increments. Go to WDATA_ACK (ACK), then WDATA again.
  - RDATA: drive bit 7 during the ACK-release `scl_fall`, then one bit per `scl_fall`. `sda_oe` = ~bit. After 8 bits, release on `scl_fall` and go to RACK.
  - RACK: sample the controller's bit on `scl_rise`.
    - 0 (ACK): pointer++, reload from `rd_data`, go to RDATA.
    - 1 (NACK): pointer++, go to IDLE-wait (SDA released until STOP/START).
- The pointer is 8 bits and wraps 0xFF → 0x00.
- Repeated START with a read after a SUB write reads from the newly set pointer.

## Timing
- Pad-to-detected-edge latency is 3 `clk` cycles.
- Requirement: SCL high and low phases ≥ 4 `clk` cycles, and SDA setup to SCL rise ≥ 4 `clk` cycles.
- `wr_en` is exactly one cycle wide, 4 cycles after the SCL pad rise of bit 8. `wr_addr` and `wr_data` are held until the next write.
- `sda_oe` changes no earlier than 3 cycles after the SCL pad fall, which gives hold time for the controller.
- Reset values:
  - `sda_oe` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0.
  - pointer = 0 (so `rd_addr` = 0), state = IDLE.
  - Synchronizer flops reset to 1 (idle bus).
- An asynchronous reset mid-transaction releases SDA immediately, without waiting for a clock.
- START and `scl_fall` in the same cycle: START wins.

## Structure
- Package `dice_i2c_pkg` holds:
  - the state enum;
  - `I2C_ADDR_DEFAULT` = 7'h70;
  - the ACK/NACK constants.
- Sub-module `i2c_line_sync` holds the synchronizers, the previous stage, and the `scl_rise` / `scl_fall` / `start` / `stop` pulses.
- The top-level `i2c_reg_target` holds the FSM, the 3-bit bit counter, the 8-bit shift register and the pointer.

## Test plan
- Write 0x70, sub 0x0A, data 0x55, 0x1F, STOP → 4 ACKs; `wr_en` pulses (0x0A, 0x55) then (0x0B, 0x1F); `busy` = 0 after STOP.
- Address 0x71 → SDA never pulled low, no `wr_en`, `busy` = 0 after the NACK bit.
- Write sub 0x05, repeated START, read 0x70, `rd_data` model {0x05: 0xA5, 0x06: 0x3C}, controller ACKs then NACKs → bytes 0xA5, 0x3C on SDA; final `rd_addr` = 0x07.
- Sub 0xFF, data 0x11, 0x22 → writes to 0xFF then 0x00 (wrap).
- STOP after 5 bits of a data byte → no `wr_en`; FSM in IDLE; the next write succeeds.
- `rst_n` asserted while `sda_oe` = 1 during an ACK → `sda_oe` = 0 before the next clk edge; all outputs at reset values; the next full write transaction ACKs normally.

Source files
------------

// File: rtl/dice_i2c_pkg.sv
// Shared definitions for the dice I2C register-access target.
//   I2C_ADDR_DEFAULT : default 7-bit target address
//   I2C_ACK/I2C_NACK : SDA level of the acknowledge bit
//   i2c_state_e      : target FSM states
package dice_i2c_pkg;

  localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h70;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchronizer and bus-condition detector for SCL/SDA.
//   clk, rst_n        : system clock, async active-low reset
//   scl_in, sda_in    : asynchronous pad inputs
//   scl, sda          : synchronized levels
//   scl_rise/scl_fall : one-cycle SCL edge pulses
//   start/stop        : one-cycle START / STOP pulses (SDA edge while SCL high)
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] are the 2-FF synchronizer, [2] is the previous-value stage.
  // Reset to 1 so an idle bus produces no edges when reset releases.
  logic [2:0] scl_sr, sda_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_in};
      sda_sr <= {sda_sr[1:0], sda_in};
    end
  end

  assign scl      = scl_sr[1];
  assign sda      = sda_sr[1];
  assign scl_rise =  scl_sr[1] & ~scl_sr[2];
  assign scl_fall = ~scl_sr[1] &  scl_sr[2];
  // SCL must be high in both stages so an SDA edge racing an SCL edge
  // is not mistaken for a bus condition.
  assign start    = scl_sr[1] & scl_sr[2] & ~sda_sr[1] &  sda_sr[2];
  assign stop     = scl_sr[1] & scl_sr[2] &  sda_sr[1] & ~sda_sr[2];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target giving register read/write access over SCL/SDA.
//   clk, rst_n      : system clock, async active-low reset
//   scl_in, sda_in  : pad inputs
//   sda_oe          : 1 = pull SDA low (pad output value tied 0)
//   wr_en           : one-cycle write strobe with wr_addr/wr_data
//   rd_addr/rd_data : pointer to register file, combinational data back
//   busy            : FSM not idle
module i2c_reg_target
  import dice_i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = I2C_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic scl, sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n, ptr, ptr_n, wr_addr_n, wr_data_n, byte_in;
  logic       oe_n, wr_go, wr_go_n, wr_en_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      wr_go   <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      sda_oe  <= oe_n;
      wr_go   <= wr_go_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    oe_n      = sda_oe;
    wr_go_n   = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    byte_in   = {shreg[6:0], sda};

    case (state)
      ST_ADDR, ST_SUB, ST_WDATA: if (scl_rise) begin
        shreg_n = byte_in;
        cnt_n   = cnt + 3'd1;
        if (cnt == 3'd7) begin
          case (state)
            ST_ADDR:  state_n = (byte_in[7:1] == ADDR) ? ST_ADDR_ACK : ST_IDLE;
            ST_SUB:   begin ptr_n = byte_in; state_n = ST_SUB_ACK; end
            default:  begin wr_go_n = 1'b1; state_n = ST_WDATA_ACK; end
          endcase
        end
      end
      // sda_oe doubles as the ACK phase: first fall drives, second releases.
      ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: if (scl_fall) begin
        if (!sda_oe) begin
          oe_n = ~I2C_ACK;
        end else begin
          oe_n  = 1'b0;
          cnt_n = '0;
          if (state == ST_ADDR_ACK && shreg[0]) begin
            // Read: first data bit goes out on the same fall that ends ACK.
            shreg_n = rd_data;
            oe_n    = ~rd_data[7];
            state_n = ST_RDATA;
          end else if (state == ST_ADDR_ACK) begin
            state_n = ST_SUB;
          end else begin
            state_n = ST_WDATA;
          end
        end
      end
      ST_RDATA: if (scl_fall) begin
        if (cnt == 3'd7) begin
          oe_n    = 1'b0;
          cnt_n   = '0;
          state_n = ST_RACK;
        end else begin
          cnt_n   = cnt + 3'd1;
          shreg_n = {shreg[6:0], 1'b0};
          oe_n    = ~shreg[6];
        end
      end
      // cnt==1 marks "controller ACKed"; the reload waits for the next fall
      // so rd_data already reflects the incremented pointer.
      ST_RACK: begin
        if (scl_rise) begin
          ptr_n = ptr + 8'd1;
          if (sda == I2C_NACK) state_n = ST_IDLE;
          else                 cnt_n   = 3'd1;
        end else if (scl_fall && cnt == 3'd1) begin
          shreg_n = rd_data;
          oe_n    = ~rd_data[7];
          cnt_n   = '0;
          state_n = ST_RDATA;
        end
      end
      default: ;
    endcase

    if (wr_go) begin
      wr_en_n   = 1'b1;
      wr_addr_n = ptr;
      wr_data_n = shreg;
      ptr_n     = ptr + 8'd1;
    end

    if (start) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (stop) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end
  end

  assign rd_addr = ptr;
  assign busy    = (state != ST_IDLE);

endmodule
